// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: two-master OBI data-port arbiter with in-order response routing.
module obi_data_arbiter #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [6:0]  m0_wdata_intg_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [6:0]  m0_rdata_intg_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [6:0]  m1_wdata_intg_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic [6:0]  m1_rdata_intg_o,
    output logic        m1_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic [6:0]  data_wdata_intg_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic [6:0]  data_rdata_intg_i,
    input  logic        data_err_i
);
    localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MAX = CW'(MaxOutstanding);
    localparam logic [PW-1:0] LAST = PW'(MaxOutstanding - 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t state, state_nx;
    logic prio, sel_q, sel, sel_req, grant, pop;
    logic [MaxOutstanding-1:0] ids;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    always_comb begin
        sel = state == HOLD ? sel_q : (m0_req_i & m1_req_i) ? prio : m1_req_i;
        sel_req = sel ? m1_req_i : m0_req_i;
        data_req_o = sel_req & (count != MAX);
        grant = data_req_o & data_gnt_i;
        pop = data_rvalid_i & (count != '0);
        state_nx = (data_req_o & ~data_gnt_i) ? HOLD : ARB;
    end

    assign data_we_o         = sel ? m1_we_i : m0_we_i;
    assign data_be_o         = sel ? m1_be_i : m0_be_i;
    assign data_addr_o       = sel ? m1_addr_i : m0_addr_i;
    assign data_wdata_o      = sel ? m1_wdata_i : m0_wdata_i;
    assign data_wdata_intg_o = sel ? m1_wdata_intg_i : m0_wdata_intg_i;
    assign m0_gnt_o          = grant & ~sel;
    assign m1_gnt_o          = grant & sel;
    assign m0_rvalid_o       = pop & ~ids[rptr];
    assign m1_rvalid_o       = pop & ids[rptr];
    assign m0_rdata_o        = data_rdata_i;
    assign m1_rdata_o        = data_rdata_i;
    assign m0_rdata_intg_o   = data_rdata_intg_i;
    assign m1_rdata_intg_o   = data_rdata_intg_i;
    assign m0_err_o          = data_err_i;
    assign m1_err_o          = data_err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARB;
            prio  <= 1'b0;
            sel_q <= 1'b0;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == HOLD) sel_q <= sel;
            if (grant) begin
                ids[wptr] <= sel;
                wptr <= wptr == LAST ? '0 : wptr + 1'b1;
                prio <= ~sel;
            end
            if (pop) rptr <= rptr == LAST ? '0 : rptr + 1'b1;
            count <= count + CW'(grant) - CW'(pop);
        end
    end

    // A response with nothing outstanding is dropped; flag it for whoever is watching.
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(data_rvalid_i && count == '0))
            else $warning("obi_data_arbiter: stray rvalid with no outstanding transaction");
    end
endmodule
